demod_seq_ctrl: RTL and testbench

DEMOD_SEQ_CTRL -- requirements
Module: demod_seq_ctrl

---
 rtl/demod_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_demod_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demod_seq_ctrl.sv
// Demodulator acquisition sequencer: HOLD -> CACQ -> BACQ -> TRACK, with a 1-cycle gated bit output.
// Define DEMOD_SEQ_STATS_EN to build the lock_loss_cnt statistics counter; otherwise the port reads 0.
module demod_seq_ctrl #(
  parameter int RST_HOLD_CYC      = 16,
  parameter int COSTAS_SETTLE_CYC = 1024,
  parameter int CACQ_TIMEOUT_CYC  = 65535,
  parameter int PREAMBLE_LEN      = 16,
  parameter int BACQ_TIMEOUT_BITS = 512,
  parameter int LOSS_CYC          = 64
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        costas_lock,
  input  logic        bitsync_data,
  input  logic        bitsync_data_valid,
  output logic        costas_rst,
  output logic        bitsync_rst,
  output logic [1:0]  demod_state,
  output logic        sync_locked,
  output logic        out_data,
  output logic        out_valid,
  output logic [15:0] lock_loss_cnt
);

  if (RST_HOLD_CYC < 1 || RST_HOLD_CYC > 65535 ||
      COSTAS_SETTLE_CYC < 1 || COSTAS_SETTLE_CYC > 65535 ||
      CACQ_TIMEOUT_CYC < 1 || CACQ_TIMEOUT_CYC > 65535 ||
      PREAMBLE_LEN < 1 || PREAMBLE_LEN > 65535 ||
      BACQ_TIMEOUT_BITS < 1 || BACQ_TIMEOUT_BITS > 65535 ||
      LOSS_CYC < 1 || LOSS_CYC > 65535) begin : g_param_range
    $fatal(1, "demod_seq_ctrl: every parameter must lie in 1..65535");
  end

  localparam logic [16:0] HOLD_LIM   = 17'(RST_HOLD_CYC);
  localparam logic [16:0] SETTLE_LIM = 17'(COSTAS_SETTLE_CYC);
  localparam logic [16:0] CACQ_LIM   = 17'(CACQ_TIMEOUT_CYC);
  localparam logic [16:0] PRE_LIM    = 17'(PREAMBLE_LEN);
  localparam logic [16:0] BTO_LIM    = 17'(BACQ_TIMEOUT_BITS);
  localparam logic [16:0] LOSS_LIM   = 17'(LOSS_CYC);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    CACQ  = 2'd1,
    BACQ  = 2'd2,
    TRACK = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] hold_cnt, lock_run, cacq_cnt, loss_cnt, alt_run, bit_cnt;
  logic        prev_bit;

  logic [15:0] hold_inc, lock_inc, cacq_inc, loss_inc, alt_inc, bit_inc;
  logic        in_bt, hold_done, settle, cacq_to, loss_hit, pre_hit, bacq_to;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Each *_inc is the counter value after this cycle if the state is kept.
  assign hold_inc = sat_inc(hold_cnt);
  assign lock_inc = costas_lock ? sat_inc(lock_run) : 16'd0;
  assign cacq_inc = sat_inc(cacq_cnt);
  assign loss_inc = costas_lock ? 16'd0 : sat_inc(loss_cnt);
  assign alt_inc  = (bit_cnt == 16'd0 || bitsync_data == prev_bit) ? 16'd1 : sat_inc(alt_run);
  assign bit_inc  = sat_inc(bit_cnt);

  assign in_bt     = (state == BACQ) || (state == TRACK);
  assign hold_done = {1'b0, hold_inc} >= HOLD_LIM;
  assign settle    = {1'b0, lock_inc} >= SETTLE_LIM;
  assign cacq_to   = {1'b0, cacq_inc} >= CACQ_LIM;
  assign loss_hit  = in_bt && !costas_lock && ({1'b0, loss_inc} >= LOSS_LIM);
  assign pre_hit   = bitsync_data_valid && ({1'b0, alt_inc} >= PRE_LIM);
  assign bacq_to   = bitsync_data_valid && ({1'b0, bit_inc} >= BTO_LIM);

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = HOLD;
    end else begin
      case (state)
        HOLD:    if (hold_done) state_nxt = CACQ;
        CACQ:    if (settle) state_nxt = BACQ;
                 else if (cacq_to) state_nxt = HOLD;
        BACQ:    if (loss_hit) state_nxt = HOLD;
                 else if (pre_hit) state_nxt = TRACK;
                 else if (bacq_to) state_nxt = HOLD;
        TRACK:   if (loss_hit) state_nxt = HOLD;
        default: state_nxt = HOLD;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      hold_cnt  <= 16'd0;
      lock_run  <= 16'd0;
      cacq_cnt  <= 16'd0;
      loss_cnt  <= 16'd0;
      alt_run   <= 16'd0;
      bit_cnt   <= 16'd0;
      prev_bit  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Counters run only while the state is kept, so every entry starts them from zero.
      hold_cnt <= (state == HOLD && state_nxt == HOLD && enable) ? hold_inc : 16'd0;
      lock_run <= (state == CACQ && state_nxt == CACQ) ? lock_inc : 16'd0;
      cacq_cnt <= (state == CACQ && state_nxt == CACQ) ? cacq_inc : 16'd0;
      loss_cnt <= (in_bt && (state_nxt == BACQ || state_nxt == TRACK)) ? loss_inc : 16'd0;
      if (state == BACQ && state_nxt == BACQ) begin
        if (bitsync_data_valid) begin
          alt_run  <= alt_inc;
          bit_cnt  <= bit_inc;
          prev_bit <= bitsync_data;
        end
      end else begin
        alt_run  <= 16'd0;
        bit_cnt  <= 16'd0;
        prev_bit <= 1'b0;
      end
      // The strobe that completes the preamble is sampled in BACQ and is therefore dropped.
      out_valid <= bitsync_data_valid && (state == TRACK);
      out_data  <= bitsync_data_valid && (state == TRACK) && bitsync_data;
    end
  end

`ifdef DEMOD_SEQ_STATS_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= 16'd0;
    end else if (state == TRACK && enable && loss_hit) begin
      lock_loss_cnt <= sat_inc(lock_loss_cnt);
    end
  end
`else
  assign lock_loss_cnt = 16'd0;
`endif

  assign demod_state = state;
  assign costas_rst  = (state == HOLD);
  assign bitsync_rst = (state == HOLD) || (state == CACQ);
  assign sync_locked = (state == TRACK);

endmodule

// File: tb/tb_demod_seq_ctrl.sv
// Directed-plus-random bench for demod_seq_ctrl against a queue-based behavioural model.
module tb_demod_seq_ctrl;
  localparam int RST_HOLD = 16;
  localparam int SETTLE   = 1024;
  localparam int CTO      = 3000;
  localparam int PL       = 16;
  localparam int BTO      = 512;
  localparam int LOSS     = 64;
`ifdef DEMOD_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst_n, enable, costas_lock, bitsync_data, bitsync_data_valid;
  logic        costas_rst, bitsync_rst, sync_locked, out_data, out_valid;
  logic [1:0]  demod_state;
  logic [15:0] lock_loss_cnt;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  always #5 sys_clk = ~sys_clk;

  demod_seq_ctrl #(
    .RST_HOLD_CYC(RST_HOLD), .COSTAS_SETTLE_CYC(SETTLE), .CACQ_TIMEOUT_CYC(CTO),
    .PREAMBLE_LEN(PL), .BACQ_TIMEOUT_BITS(BTO), .LOSS_CYC(LOSS)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .costas_lock(costas_lock),
    .bitsync_data(bitsync_data), .bitsync_data_valid(bitsync_data_valid),
    .costas_rst(costas_rst), .bitsync_rst(bitsync_rst), .demod_state(demod_state),
    .sync_locked(sync_locked), .out_data(out_data), .out_valid(out_valid),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // Reference model: state number, time spent in each phase, and the bits received in BACQ.
  int m_state, m_hold, m_lockrun, m_cacq, m_loss, m_exits;
  bit m_ov, m_od;
  bit m_bits[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_hold = 0; m_lockrun = 0; m_cacq = 0; m_loss = 0; m_exits = 0;
    m_ov = 1'b0; m_od = 1'b0;
    m_bits.delete();
  endfunction

  // True when the most recent PL received bits strictly alternate.
  function automatic bit preamble_seen();
    int n = m_bits.size();
    if (n < PL) return 1'b0;
    for (int k = n - PL; k < n - 1; k++)
      if (m_bits[k] == m_bits[k+1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(input bit en, input bit lock, input bit d, input bit v);
    int nxt = m_state;
    int lr_n = lock ? m_lockrun + 1 : 0;
    int loss_n = lock ? 0 : m_loss + 1;
    m_ov = v && (m_state == 3);
    m_od = m_ov && d;
    if (m_state == 2 && v) m_bits.push_back(d);
    if (!en) nxt = 0;
    else if (m_state == 0) begin
      if (m_hold + 1 >= RST_HOLD) nxt = 1;
    end else if (m_state == 1) begin
      if (lr_n >= SETTLE) nxt = 2;
      else if (m_cacq + 1 >= CTO) nxt = 0;
    end else begin
      if (loss_n >= LOSS) nxt = 0;
      else if (m_state == 2 && v && preamble_seen()) nxt = 3;
      else if (m_state == 2 && v && m_bits.size() >= BTO) nxt = 0;
    end
    if (m_state == 3 && en && nxt == 0) m_exits++;
    m_hold    = (m_state == 0 && nxt == 0 && en) ? m_hold + 1 : 0;
    m_lockrun = (m_state == 1 && nxt == 1) ? lr_n : 0;
    m_cacq    = (m_state == 1 && nxt == 1) ? m_cacq + 1 : 0;
    m_loss    = (m_state >= 2 && nxt >= 2) ? loss_n : 0;
    if (nxt != 2) m_bits.delete();
    m_state = nxt;
  endfunction

  task automatic tick(input bit d, input bit v);
    bitsync_data = d;
    bitsync_data_valid = v;
    @(posedge sys_clk);
    model_step(enable, costas_lock, d, v);
    #1;
    chk("state", 32'(demod_state), 32'(m_state));
    chk("rst_lock_outs", 32'({costas_rst, bitsync_rst, sync_locked}),
        32'({m_state == 0, m_state <= 1, m_state == 3}));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("lock_loss_cnt", 32'(lock_loss_cnt), STATS ? 32'(m_exits) : 32'd0);
  endtask

  task automatic send_bit(input bit d);
    int gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) tick(1'($urandom), 1'b0);
    tick(d, 1'b1);
  endtask

  task automatic count_until(input logic [1:0] s, input int limit, output int n);
    n = 0;
    while (demod_state !== s && n < limit) begin
      tick(1'($urandom), 1'b0);
      n++;
    end
  endtask

  task automatic go_bacq();
    int n;
    enable = 1'b1;
    costas_lock = 1'b1;
    count_until(2'd2, 4000, n);
    chk("reach_bacq", 32'(demod_state), 32'd2);
  endtask

  task automatic go_track();
    bit b = 1'($urandom);
    go_bacq();
    for (int i = 0; i < PL; i++) begin
      send_bit(b);
      b = ~b;
    end
    chk("reach_track", 32'(demod_state), 32'd3);
  endtask

  initial begin
    int n;
    bit b;
    rst_n = 1'b1; enable = 1'b0; costas_lock = 1'b0;
    bitsync_data = 1'b0; bitsync_data_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_state", 32'(demod_state), 32'd0);
    chk("reset_outs", 32'({costas_rst, bitsync_rst, sync_locked, out_valid, out_data}), 32'b11000);
    chk("reset_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    rst_n = 1'b1;

    // Clean acquisition
    enable = 1'b1; costas_lock = 1'b1;
    count_until(2'd1, 100, n);
    chk("hold_len", 32'(n), 32'd16);
    count_until(2'd2, 2000, n);
    chk("settle_len", 32'(n), 32'd1024);
    b = 1'($urandom);
    for (int i = 0; i < PL - 1; i++) begin
      send_bit(b);
      b = ~b;
    end
    chk("pre15_still_bacq", 32'(demod_state), 32'd2);
    send_bit(b);
    chk("pre16_track", 32'(demod_state), 32'd3);
    chk("pre16_locked", 32'(sync_locked), 32'd1);
    chk("preamble_not_fwd", 32'(out_valid), 32'd0);
    b = 1'($urandom);
    tick(b, 1'b1);
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_out_data", 32'(out_data), 32'(b));
    for (int i = 0; i < 40; i++) send_bit(1'($urandom));

    // Loss of lock: 63-cycle drop survives, 64-cycle drop exits
    costas_lock = 1'b0;
    repeat (LOSS - 1) tick(1'($urandom), 1'b0);
    chk("loss63_track", 32'(demod_state), 32'd3);
    costas_lock = 1'b1;
    repeat (5) tick(1'($urandom), 1'b0);
    costas_lock = 1'b0;
    repeat (LOSS - 1) tick(1'($urandom), 1'b0);
    chk("loss63b_track", 32'(demod_state), 32'd3);
    tick(1'($urandom), 1'b0);
    chk("loss64_hold", 32'(demod_state), 32'd0);
    chk("loss64_out_valid", 32'(out_valid), 32'd0);
    chk("loss64_cnt", 32'(lock_loss_cnt), STATS ? 32'd1 : 32'd0);

    // Broken preamble: 1010101, repeated 1, then alternating from 0
    go_bacq();
    b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_bit(b);
      b = ~b;
    end
    send_bit(1'b1);
    b = 1'b0;
    for (int i = 0; i < PL - 2; i++) begin
      send_bit(b);
      b = ~b;
    end
    chk("broken_not_yet", 32'(demod_state), 32'd2);
    send_bit(b);
    chk("broken_track", 32'(demod_state), 32'd3);

    // Enable-forced exit from TRACK does not count as a loss
    enable = 1'b0;
    tick(1'b0, 1'b0);
    chk("en_exit_hold", 32'(demod_state), 32'd0);
    chk("en_exit_cnt", 32'(lock_loss_cnt), STATS ? 32'd1 : 32'd0);
    repeat (3) tick(1'($urandom), 1'b0);
    enable = 1'b1;
    count_until(2'd1, 100, n);
    chk("rehold_len", 32'(n), 32'd16);

    // BACQ timeout on constant zeros
    go_bacq();
    for (int i = 0; i < BTO - 1; i++) send_bit(1'b0);
    chk("bto511_bacq", 32'(demod_state), 32'd2);
    send_bit(1'b0);
    chk("bto512_hold", 32'(demod_state), 32'd0);
    chk("bto512_rsts", 32'({costas_rst, bitsync_rst}), 32'b11);

    // Enable override in BACQ, then on the strobe completing the preamble
    go_bacq();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    enable = 1'b0;
    tick(1'b0, 1'b0);
    chk("en_bacq_hold", 32'(demod_state), 32'd0);
    go_bacq();
    b = 1'($urandom);
    for (int i = 0; i < PL - 1; i++) begin
      send_bit(b);
      b = ~b;
    end
    enable = 1'b0;
    tick(b, 1'b1);
    chk("en_pre16_hold", 32'(demod_state), 32'd0);
    chk("en_pre16_unlocked", 32'(sync_locked), 32'd0);
    repeat (4) tick(1'($urandom), 1'b0);

    // CACQ timeout with a glitchy carrier lock
    enable = 1'b1;
    count_until(2'd1, 100, n);
    chk("cacq_entry", 32'(n), 32'd16);
    n = 0;
    while (demod_state === 2'd1 && n < CTO + 100) begin
      costas_lock = ($urandom_range(0, 7) != 0);
      tick(1'($urandom), 1'b0);
      n++;
    end
    chk("cacq_timeout_len", 32'(n), 32'(CTO));
    chk("cacq_timeout_hold", 32'(demod_state), 32'd0);

    // Asynchronous reset in TRACK, right after a forwarded strobe
    go_track();
    tick(1'b1, 1'b1);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(demod_state), 32'd0);
    chk("arst_outs", 32'({costas_rst, bitsync_rst, sync_locked, out_valid, out_data}), 32'b11000);
    chk("arst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    count_until(2'd1, 100, n);
    chk("arst_hold_len", 32'(n), 32'd16);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passes, total);
    $fatal(1, "watchdog");
  end

endmodule
